// File: rtl/branch_update_queue_if.sv
// Resolve, retire, update and redirect signals between
// the execution units, ROB, predictor and branch_update_queue.
interface branch_update_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_pc;
  logic          res_taken;
  logic [63:0]   res_target;
  logic          res_pred_taken;
  logic [63:0]   res_pred_target;
  logic          commit_valid;
  logic          flush;
  logic          update_valid;
  logic [63:0]   update_pc;
  logic          update_taken;
  logic [63:0]   update_target;
  logic          redirect_valid;
  logic [63:0]   redirect_pc;
  logic [CW-1:0] count;
  logic          commit_err;

  modport master (
    output res_valid, res_pc, res_taken, res_target,
    output res_pred_taken, res_pred_target,
    output commit_valid, flush,
    input  res_ready, update_valid, update_pc,
    input  update_taken, update_target,
    input  redirect_valid, redirect_pc,
    input  count, commit_err
  );

  modport slave (
    input  res_valid, res_pc, res_taken, res_target,
    input  res_pred_taken, res_pred_target,
    input  commit_valid, flush,
    output res_ready, update_valid, update_pc,
    output update_taken, update_target,
    output redirect_valid, redirect_pc,
    output count, commit_err
  );
endinterface

// File: rtl/branch_update_queue.sv
// Resolved-branch FIFO: redirects on mispredict at resolve,
// releases predictor updates in retire order.
module branch_update_queue #(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst_n,
  branch_update_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [63:0]   r_pc  [DEPTH];
  logic          r_tk  [DEPTH];
  logic [63:0]   r_tg  [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_upd_v;
  logic [63:0]   r_upd_pc;
  logic          r_upd_tk;
  logic [63:0]   r_upd_tg;
  logic          r_rd_v;
  logic [63:0]   r_rd_pc;
  logic          r_err;

  logic w_ready;
  logic w_empty;
  logic w_acc;
  logic w_pop;
  logic w_misp;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count != CW'(DEPTH)) && !bus.flush;
  assign w_acc   = bus.res_valid && w_ready;
  assign w_pop   = bus.commit_valid && !w_empty;
  assign w_misp  = (bus.res_taken != bus.res_pred_taken) ||
                   (bus.res_taken &&
                    (bus.res_target != bus.res_pred_target));

  // Entry storage carries no reset; only the pointers matter.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_pc[r_tail] <= bus.res_pc;
      r_tk[r_tail] <= bus.res_taken;
      r_tg[r_tail] <= bus.res_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + 1'b1;
      if (w_acc) r_tail <= r_tail + 1'b1;
      r_count <= r_count + CW'(w_acc) - CW'(w_pop);
    end
  end

  // The retiring branch is older than the flush, so it still updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_v  <= 1'b0;
      r_upd_pc <= '0;
      r_upd_tk <= 1'b0;
      r_upd_tg <= '0;
    end else begin
      r_upd_v <= w_pop;
      if (w_pop) begin
        r_upd_pc <= r_pc[r_head];
        r_upd_tk <= r_tk[r_head];
        r_upd_tg <= r_tg[r_head];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v  <= 1'b0;
      r_rd_pc <= '0;
      r_err   <= 1'b0;
    end else begin
      r_rd_v <= w_acc && w_misp;
      if (w_acc && w_misp)
        r_rd_pc <= bus.res_taken ? bus.res_target
                                 : bus.res_pc + 64'd4;
      if (bus.commit_valid && w_empty)
        r_err <= 1'b1;
    end
  end

  assign bus.res_ready      = w_ready;
  assign bus.update_valid   = r_upd_v;
  assign bus.update_pc      = r_upd_pc;
  assign bus.update_taken   = r_upd_tk;
  assign bus.update_target  = r_upd_tg;
  assign bus.redirect_valid = r_rd_v;
  assign bus.redirect_pc    = r_rd_pc;
  assign bus.count          = r_count;
  assign bus.commit_err     = r_err;
endmodule
